// File: rtl/modulo_varredura4_if.sv
// modulo_varredura4_if: scan control inputs and 1:4 demux drive outputs
interface modulo_varredura4_if;
    logic       RUN;
    logic       HOLD;
    logic [3:0] MASK;
    logic [1:0] S;
    logic       E;
    logic       SLOT_START;

    modport master (output RUN, HOLD, MASK, input S, E, SLOT_START);
    modport slave  (input RUN, HOLD, MASK, output S, E, SLOT_START);
endinterface

// File: rtl/modulo_varredura4.sv
// modulo_varredura4: time-sliced 4-channel scanner driving a 1:4 demux with blanking between channels
module modulo_varredura4 #(
    parameter int DIV   = 1000,
    parameter int BLANK = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    modulo_varredura4_if.slave  bus
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LB = CW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [CW-1:0] LD = CW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, BLANKING, ACTIVE} state_t;

    state_t        r_state, w_state_n, w_slot_st;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [1:0]    r_s, w_s_n, w_first, w_next, w_p;
    logic          r_e, r_ss, w_e_n, w_start, w_go;
    logic [7:0]    w_sh;
    logic [3:0]    w_rot;

    assign bus.S          = r_s;
    assign bus.E          = r_e;
    assign bus.SLOT_START = r_ss;

    // Channel search: lowest set bit for a fresh start, circular search from S+1 at slot end
    always_comb begin
        w_go      = bus.RUN && (bus.MASK != 4'b0000);
        w_slot_st = (BLANK == 0) ? ACTIVE : BLANKING;
        w_first   = bus.MASK[0] ? 2'd0 : bus.MASK[1] ? 2'd1 : bus.MASK[2] ? 2'd2 : 2'd3;
        w_sh      = {bus.MASK, bus.MASK} >> ({1'b0, r_s} + 3'd1);
        w_rot     = w_sh[3:0];
        w_p       = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
        w_next    = r_s + 2'd1 + w_p;
    end

    // State register plus registered outputs; reset aborts any slot with E low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_s     <= 2'b00;
            r_e     <= 1'b0;
            r_ss    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_s     <= w_s_n;
            r_e     <= w_e_n;
            r_ss    <= w_start;
        end
    end

    // Next state: stop has priority, then slot start, blanking end, slot end (hold or advance)
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt + 1'b1;
        w_s_n     = r_s;
        w_start   = 1'b0;
        if (!w_go) begin
            w_state_n = IDLE;
            w_cnt_n   = '0;
        end else if (r_state == IDLE) begin
            w_state_n = w_slot_st;
            w_cnt_n   = '0;
            w_s_n     = w_first;
            w_start   = 1'b1;
        end else if (r_state == BLANKING) begin
            w_state_n = (r_cnt == LB) ? ACTIVE : BLANKING;
        end else if (r_cnt == LD) begin
            w_cnt_n = '0;
            if (!bus.HOLD) begin
                w_state_n = w_slot_st;
                w_s_n     = w_next;
                w_start   = 1'b1;
            end
        end
    end

    // Output: demux enabled only while active and the selected channel is still masked in
    always_comb begin
        w_e_n = (w_state_n == ACTIVE) ? bus.MASK[w_s_n] : 1'b0;
    end
endmodule

// File: tb/tb_modulo_varredura4.sv
// tb_modulo_varredura4: scoreboard bench for two scanner instances (BLANK=2 and BLANK=0, DIV=10)
module tb_modulo_varredura4;
    localparam int DIV = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    modulo_varredura4_if if0 ();
    modulo_varredura4_if if1 ();

    modulo_varredura4 #(.DIV(DIV), .BLANK(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    modulo_varredura4 #(.DIV(DIV), .BLANK(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    int checks = 0;
    int errors = 0;

    logic       run, hold;
    logic [3:0] mask;

    // reference model state, index 0 -> BLANK=2, index 1 -> BLANK=0
    bit         m_on [2];
    logic [1:0] m_s  [2];
    int         m_pos[2];
    bit         m_blk[2];
    bit         m_e  [2];
    bit         m_ss [2];
    int         bl   [2] = '{2, 0};

    logic [4:0] exp_q[$];

    int ss_cnt, bad_s;

    function automatic logic [1:0] pick(input logic [1:0] from, input logic [3:0] m);
        logic [1:0] c;
        for (int k = 0; k < 4; k++) begin
            c = from + 2'(k);
            if (m[c]) return c;
        end
        return from;
    endfunction

    task automatic drive(input logic r, input logic h, input logic [3:0] m);
        run = r; hold = h; mask = m;
        if0.RUN = r; if0.HOLD = h; if0.MASK = m;
        if1.RUN = r; if1.HOLD = h; if1.MASK = m;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_on[d] = 0; m_s[d] = 2'd0; m_pos[d] = 0; m_blk[d] = 1; m_e[d] = 0; m_ss[d] = 0;
        end
    endtask

    task automatic model_edge(input int d);
        if (!run || mask == 4'b0000) begin
            m_on[d] = 0; m_e[d] = 0; m_ss[d] = 0;
        end else begin
            if (!m_on[d]) begin
                m_on[d] = 1; m_s[d] = pick(2'd0, mask); m_pos[d] = 0; m_blk[d] = 1; m_ss[d] = 1;
            end else if (m_pos[d] == DIV - 1) begin
                m_pos[d] = 0;
                if (hold) begin
                    m_blk[d] = 0; m_ss[d] = 0;
                end else begin
                    m_s[d] = pick(m_s[d] + 2'd1, mask); m_blk[d] = 1; m_ss[d] = 1;
                end
            end else begin
                m_pos[d]++; m_ss[d] = 0;
            end
            m_e[d] = (m_blk[d] && m_pos[d] < bl[d]) ? 1'b0 : mask[m_s[d]];
        end
    endtask

    // one clock: model predicts at the edge, DUT outputs compared 1 time unit later
    task automatic step();
        logic [4:0] x;
        logic [3:0] act;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            model_edge(d);
            exp_q.push_back({d[0], m_s[d], m_e[d], m_ss[d]});
        end
        #1;
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            act = x[4] ? {if1.S, if1.E, if1.SLOT_START} : {if0.S, if0.E, if0.SLOT_START};
            checks++;
            assert (act === x[3:0]) else begin
                errors++;
                $error("FAIL sb_dut%0d t=%0t got {S,E,SS}=%b exp %b", x[4], $time, act, x[3:0]);
            end
        end
        ss_cnt += int'(if0.SLOT_START);
        if (if0.S == 2'd0 || if0.S == 2'd2) bad_s++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset(input string tag);
        checks++;
        assert ({if0.S, if0.E, if0.SLOT_START, if1.S, if1.E, if1.SLOT_START} === 8'h00) else begin
            errors++;
            $error("FAIL %s got %b %b exp 0000 0000", tag, {if0.S, if0.E, if0.SLOT_START},
                   {if1.S, if1.E, if1.SLOT_START});
        end
    endtask

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s wait bound expired", tag);
    endtask

    initial begin
        int n;
        model_reset();
        drive(1'b0, 1'b0, 4'b0000);
        #2;
        check_reset("reset_init");
        #10 rst_n = 1'b1;
        steps(2);
        // full scan
        drive(1'b1, 1'b0, 4'b1111);
        ss_cnt = 0;
        steps(40);
        check_val("full_scan_slot_starts", ss_cnt, 4);
        steps(5);
        // sparse mask
        drive(1'b1, 1'b0, 4'b1010);
        steps(10);
        bad_s = 0;
        steps(30);
        check_val("sparse_bad_s", bad_s, 0);
        // hold on channel 2 across two slot ends
        drive(1'b1, 1'b0, 4'b1111);
        n = 0;
        while (!(m_on[0] && m_s[0] == 2'd2 && m_pos[0] >= 2) && n < 60) begin step(); n++; end
        if (n == 60) timeout("hold_wait");
        drive(1'b1, 1'b1, 4'b1111);
        ss_cnt = 0;
        steps(25);
        check_val("hold_slot_starts", ss_cnt, 0);
        check_val("hold_s", int'(if0.S), 2);
        drive(1'b1, 1'b0, 4'b1111);
        steps(15);
        // stop at cnt=5 of S=1, then restart on channel 2
        n = 0;
        while (!(m_s[0] == 2'd1 && m_pos[0] == 5) && n < 60) begin step(); n++; end
        if (n == 60) timeout("stop_wait");
        drive(1'b0, 1'b0, 4'b1111);
        steps(3);
        check_val("stop_s_held", int'(if0.S), 1);
        drive(1'b1, 1'b0, 4'b0100);
        steps(12);
        // clear the active channel's mask bit mid-slot
        drive(1'b1, 1'b0, 4'b1111);
        steps(3);
        n = 0;
        while (!(m_pos[0] == 4) && n < 30) begin step(); n++; end
        if (n == 30) timeout("mask_wait");
        drive(1'b1, 1'b0, 4'b1111 & ~(4'b0001 << m_s[0]));
        steps(20);
        // MASK=0 forces idle, then single channel 0
        drive(1'b1, 1'b0, 4'b0000);
        steps(2);
        drive(1'b1, 1'b0, 4'b0001);
        n = 0;
        while (!(m_pos[0] == 6) && n < 30) begin step(); n++; end
        if (n == 30) timeout("reset_wait");
        #2 rst_n = 1'b0;
        #1;
        check_reset("reset_mid_slot");
        model_reset();
        #1 rst_n = 1'b1;
        ss_cnt = 0;
        steps(30);
        check_val("single_ch_slot_starts", ss_cnt, 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
